// File: rtl/line_buffer.sv
// Raster-order line buffer: keeps the two previous rows in ping-pong line memories and emits
// one vertical 3-pixel column (rows y-2, y-1, y) per accepted pixel from row 2 onward.
module line_buffer #(
  parameter int unsigned XB    = 10,
  parameter int unsigned YB    = 10,
  parameter int unsigned PB    = 8,
  parameter int unsigned NM    = 4,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PB-1:0]    pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic             pix_ready,
  output logic [NM*PB-1:0] col_data,
  output logic             en,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_t;

  localparam logic [XB-1:0] X_LAST = XB'(IMG_W - 1);
  localparam logic [YB-1:0] Y_LAST = YB'(IMG_H - 1);
  localparam logic [YB-1:0] Y_ONE  = YB'(1);
  localparam logic [YB-1:0] Y_TWO  = YB'(2);

  state_t             state_q, state_d;
  logic [XB-1:0]      x_q, x_d;
  logic [YB-1:0]      y_q, y_d;
  logic               sel_q, sel_d;
  logic               en_q, en_d;
  logic               fd_q, fd_d;
  logic               rdy_q, rdy_d;
  logic [NM*PB-1:0]   col_q, col_d;

  logic [PB-1:0]      bank0 [IMG_W];
  logic [PB-1:0]      bank1 [IMG_W];

  logic               accept;
  logic               start;
  logic               live;
  logic [XB-1:0]      eff_x;
  logic               eff_sel;
  logic [PB-1:0]      rd_b0, rd_b1;
  logic [PB-1:0]      rd_prev, rd_old;

  assign accept = pix_valid & rdy_q;
  assign start  = accept & sof & (state_q != DONE);
  assign live   = accept & ~sof & ((state_q == FILL) | (state_q == STREAM));

  // A sof pixel is (0,0) with bank select 0, whatever the counters held before.
  assign eff_x   = start ? '0 : x_q;
  assign eff_sel = start ? 1'b0 : sel_q;

  always_comb begin
    rd_b0   = bank0[eff_x];
    rd_b1   = bank1[eff_x];
    rd_prev = eff_sel ? rd_b1 : rd_b0;
    rd_old  = eff_sel ? rd_b0 : rd_b1;
  end

  // Line memories are intentionally not reset; stale contents never reach col_data.
  always_ff @(posedge clk) begin
    if (start | live) begin
      if (eff_sel) begin
        bank0[eff_x] <= pix_in;
      end else begin
        bank1[eff_x] <= pix_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    en_d    = 1'b0;
    fd_d    = 1'b0;
    col_d   = col_q;

    if (start) begin
      state_d = FILL;
      x_d     = XB'(1);
      y_d     = '0;
      sel_d   = 1'b0;
    end else if (live) begin
      if (y_q >= Y_TWO) begin
        en_d              = 1'b1;
        col_d             = '0;
        col_d[2*PB +: PB] = pix_in;
        col_d[PB +: PB]   = rd_prev;
        col_d[0 +: PB]    = rd_old;
      end
      if (x_q == X_LAST) begin
        x_d   = '0;
        y_d   = y_q + 1'b1;
        sel_d = ~sel_q;
        if ((state_q == FILL) && (y_q == Y_ONE)) begin
          state_d = STREAM;
        end
        if ((state_q == STREAM) && (y_q == Y_LAST)) begin
          state_d = DONE;
          fd_d    = 1'b1;
          y_d     = '0;
          sel_d   = 1'b0;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end

    rdy_d = (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
      rdy_q   <= 1'b0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
      rdy_q   <= rdy_d;
      col_q   <= col_d;
    end
  end

  assign pix_ready  = rdy_q;
  assign col_data   = col_q;
  assign en         = en_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer on a 4x4 image; pixel value = offset + 16*y + x.
module tb_line_buffer;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned PB = 8;
  localparam int unsigned NM = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [PB-1:0]    pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             sof = 1'b0;
  logic             pix_ready;
  logic [NM*PB-1:0] col_data;
  logic             en;
  logic             frame_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        s_en, s_fd, s_rdy;
  logic [31:0] s_col;

  line_buffer #(
    .XB(2), .YB(2), .PB(PB), .NM(NM), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .pix_ready(pix_ready), .col_data(col_data), .en(en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; applies inputs over one rising edge and samples at the next fall.
  task automatic step(input logic [7:0] p, input logic v, input logic s);
    pix_in    = p;
    pix_valid = v;
    sof       = s;
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    s_en  = en;
    s_fd  = frame_done;
    s_rdy = pix_ready;
    s_col = col_data;
  endtask

  function automatic logic [7:0] pval(input logic [7:0] off, input int unsigned x,
                                      input int unsigned y);
    return 8'(off + 16 * y + x);
  endfunction

  function automatic logic [31:0] col_exp(input logic [7:0] off, input int unsigned x,
                                          input int unsigned y);
    return {8'h00, pval(off, x, y), pval(off, x, y - 1), pval(off, x, y - 2)};
  endfunction

  task automatic run_frame(input logic [7:0] off, input bit bubbles, input string name);
    int unsigned pulses = 0;
    for (int unsigned y = 0; y < H; y++) begin
      for (int unsigned x = 0; x < W; x++) begin
        bit last = (x == W - 1) && (y == H - 1);
        step(pval(off, x, y), 1'b1, (x == 0) && (y == 0));
        check({name, "_en"}, {31'b0, s_en}, (y >= 2) ? 32'd1 : 32'd0);
        if (s_en) pulses++;
        if (y >= 2) check({name, "_col"}, s_col, col_exp(off, x, y));
        check({name, "_fd"}, {31'b0, s_fd}, last ? 32'd1 : 32'd0);
        if (last) check({name, "_rdy_done"}, {31'b0, s_rdy}, 32'd0);
        if (bubbles && !last) begin
          step(8'hFF, 1'b0, 1'b0);
          check({name, "_bub_en"}, {31'b0, s_en}, 32'd0);
          if (s_en) pulses++;
        end
      end
    end
    step(8'h00, 1'b0, 1'b0);
    check({name, "_idle_en"}, {31'b0, s_en}, 32'd0);
    check({name, "_rdy_after"}, {31'b0, s_rdy}, 32'd1);
    check({name, "_pulses"}, pulses, 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_en", {31'b0, en}, 32'd0);
    check("rst_fd", {31'b0, frame_done}, 32'd0);
    check("rst_col", col_data, 32'd0);
    check("rst_rdy", {31'b0, pix_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset asserted mid-frame, right after the column for (0,2)
    for (int unsigned i = 0; i < 2 * W + 1; i++) begin
      step(pval(8'h00, i % W, i / W), 1'b1, i == 0);
    end
    check("pre_rst_en", {31'b0, s_en}, 32'd1);
    check("pre_rst_col", s_col, col_exp(8'h00, 0, 2));
    #2 rst = 1'b0;
    #1;
    check("async_rst_en", {31'b0, en}, 32'd0);
    check("async_rst_fd", {31'b0, frame_done}, 32'd0);
    check("async_rst_col", col_data, 32'd0);
    check("async_rst_rdy", {31'b0, pix_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < 3 * W; i++) begin
      step(pval(8'h00, i % W, i / W), 1'b1, 1'b0);
      check("idle_drop_en", {31'b0, s_en}, 32'd0);
    end
    check("idle_rdy", {31'b0, s_rdy}, 32'd1);

    // Full frame, frame end, then a back-to-back frame
    run_frame(8'h00, 1'b0, "full");
    run_frame(8'h80, 1'b0, "b2b");

    // Bubbles between every pixel
    run_frame(8'h00, 1'b1, "bub");

    // Abort: sof re-asserted where pixel (2,1) would be
    for (int unsigned i = 0; i < W + 2; i++) begin
      step(pval(8'h40, i % W, i / W), 1'b1, i == 0);
      check("abort_old_en", {31'b0, s_en}, 32'd0);
    end
    run_frame(8'h00, 1'b0, "abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
